pipo_arbiter: RTL and testbench



---
 rtl/pipo_arb_pkg.sv | 8 +
 rtl/pipo_arbiter_rr_pick.sv | 35 +++
 rtl/pipo_arbiter.sv | 97 +++++++++
 tb/tb_pipo_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipo_arb_pkg.sv
// Shared constants for the pipo_arbiter block.
//   ST_IDLE / ST_HOLD : FSM state encodings
//   HOLD_CNT_W        : width of the post-load hold counter (covers 0..15)
package pipo_arb_pkg;
  localparam int         HOLD_CNT_W = 4;
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_HOLD    = 1'b1;
endpackage

// File: rtl/pipo_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req  : request vector
//   ptr  : index searched first; the search wraps modulo N_REQ
//   gnt  : one-hot grant (all-zero when no request)
//   idx  : index of the granted requester (0 when no request)
//   any  : at least one request is present
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);
  always_comb begin
    int   j;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = ID_W'(j);
      end
    end
  end

  assign any = |req;
endmodule

// File: rtl/pipo_arbiter.sv
// pipo_arbiter: round-robin arbiter loading one requester's word into a
// shared parallel register, then freezing it for HOLD_CYCLES cycles.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : clears q/q_owner/q_valid and returns to IDLE (pointer kept)
//   req_valid  : per-requester valid
//   req_data   : requester i's word at [i*WIDTH +: WIDTH]
//   req_ready  : one-hot grant (only in IDLE, not during rst/flush)
//   q, q_owner : registered word and the index of the requester that loaded it
//   q_valid    : q holds loaded data
//   busy       : high while the register is being held
module pipo_arbiter
  import pipo_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2,
  localparam int ID_W       = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]       q,
  output logic [ID_W-1:0]        q_owner,
  output logic                   q_valid,
  output logic                   busy
);
  // Counter preload; unused when HOLD_CYCLES is 0.
  localparam logic [HOLD_CNT_W-1:0] HOLD_INIT =
    (HOLD_CYCLES > 0) ? HOLD_CNT_W'(HOLD_CYCLES - 1) : '0;

  logic [0:0]            state;
  logic [HOLD_CNT_W-1:0] cnt;
  logic [ID_W-1:0]       ptr;
  logic [N_REQ-1:0]      gnt;
  logic [ID_W-1:0]       win;
  logic                  any;
  logic                  xfer;

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (win),
    .any (any)
  );

  // Grant is suppressed in the reset/flush cycle so nothing is handed off
  // that the register will not actually load.
  assign req_ready = (state == ST_IDLE && !rst && !flush) ? gnt : '0;
  assign xfer      = any && |(req_valid & req_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ptr     <= '0;
      q       <= '0;
      q_owner <= '0;
      q_valid <= 1'b0;
      busy    <= 1'b0;
    end else if (flush) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      q       <= '0;
      q_owner <= '0;
      q_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            q       <= req_data[win*WIDTH +: WIDTH];
            q_owner <= win;
            q_valid <= 1'b1;
            ptr     <= (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
            if (HOLD_CYCLES > 0) begin
              state <= ST_HOLD;
              cnt   <= HOLD_INIT;
              busy  <= 1'b1;
            end
          end
        end
        default: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pipo_arbiter.sv
// Scoreboard bench for pipo_arbiter. Instance a uses HOLD_CYCLES=2,
// instance b uses HOLD_CYCLES=0 for back-to-back loads.
module tb_pipo_arbiter;
  typedef struct {
    int owner;
    int data;
  } exp_t;

  logic        clk = 1'b0;
  int          tests = 0;
  int          fails = 0;
  exp_t        qa[$];
  exp_t        qb[$];

  logic        rst_a, flush_a, q_valid_a, busy_a;
  logic [3:0]  req_valid_a, req_ready_a, q_a;
  logic [15:0] req_data_a;
  logic [1:0]  q_owner_a;

  logic        rst_b, flush_b, q_valid_b, busy_b;
  logic [3:0]  req_valid_b, req_ready_b, q_b;
  logic [15:0] req_data_b;
  logic [1:0]  q_owner_b;

  always #5 clk = ~clk;

  pipo_arbiter #(.N_REQ(4), .WIDTH(4), .HOLD_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst_a), .flush(flush_a), .req_valid(req_valid_a),
    .req_data(req_data_a), .req_ready(req_ready_a), .q(q_a),
    .q_owner(q_owner_a), .q_valid(q_valid_a), .busy(busy_a));

  pipo_arbiter #(.N_REQ(4), .WIDTH(4), .HOLD_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst_b), .flush(flush_b), .req_valid(req_valid_b),
    .req_data(req_data_b), .req_ready(req_ready_b), .q(q_b),
    .q_owner(q_owner_b), .q_valid(q_valid_b), .busy(busy_b));

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh2idx(input logic [3:0] v);
    int r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Monitor a: a handshake seen at negedge must match the next expected
  // owner, and the register must show that word after the following edge.
  initial begin
    exp_t e;
    int   w;
    forever begin
      @(negedge clk);
      if (|(req_valid_a & req_ready_a)) begin
        w = oh2idx(req_ready_a);
        if (qa.size() == 0) begin
          chk("a_unexpected_grant", w, -1);
        end else begin
          e = qa.pop_front();
          chk("a_grant_idx", w, e.owner);
          @(posedge clk);
          #2;
          chk("a_q", int'(q_a), e.data);
          chk("a_q_owner", int'(q_owner_a), e.owner);
          chk("a_q_valid", int'(q_valid_a), 1);
        end
      end
    end
  end

  initial begin
    exp_t e;
    int   w;
    forever begin
      @(negedge clk);
      if (|(req_valid_b & req_ready_b)) begin
        w = oh2idx(req_ready_b);
        if (qb.size() == 0) begin
          chk("b_unexpected_grant", w, -1);
        end else begin
          e = qb.pop_front();
          chk("b_grant_idx", w, e.owner);
          @(posedge clk);
          #2;
          chk("b_q", int'(q_b), e.data);
          chk("b_q_owner", int'(q_owner_b), e.owner);
          chk("b_busy", int'(busy_b), 0);
        end
      end
    end
  end

  initial begin
    rst_a = 1'b1; flush_a = 1'b0; req_valid_a = 4'b1111; req_data_a = 16'h4321;
    rst_b = 1'b1; flush_b = 1'b0; req_valid_b = 4'b0000; req_data_b = 16'h0;

    // Reset with all requesters valid: nothing granted, outputs cleared.
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_ready", int'(req_ready_a), 0);
      chk("rst_q", int'(q_a), 0);
      chk("rst_q_valid", int'(q_valid_a), 0);
      chk("rst_busy", int'(busy_a), 0);
    end
    rst_a = 1'b0; req_valid_a = 4'b0000;
    tick();

    // Single requester 2 with 0xA; hold 2 cycles, no re-grant.
    req_data_a = 16'h0A00;
    req_valid_a = 4'b0100;
    qa.push_back('{owner: 2, data: 4'hA});
    #1 chk("single_ready", int'(req_ready_a), 4'b0100);
    tick();
    req_valid_a = 4'b0000;
    chk("single_busy0", int'(busy_a), 1);
    tick();
    chk("single_busy1", int'(busy_a), 1);
    tick();
    chk("single_busy_end", int'(busy_a), 0);
    chk("single_q_hold", int'(q_a), 4'hA);

    // Round robin from pointer 0: grants 0,1,2,3,0 three cycles apart.
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    req_data_a = 16'h4321;
    req_valid_a = 4'b1111;
    qa.push_back('{owner: 0, data: 1});
    qa.push_back('{owner: 1, data: 2});
    qa.push_back('{owner: 2, data: 3});
    qa.push_back('{owner: 3, data: 4});
    qa.push_back('{owner: 0, data: 1});
    for (int g = 0; g < 5; g++) begin
      #1 chk("rr_grant", int'(req_ready_a), 1 << (g % 4));
      tick();
      if (g == 4) req_valid_a = 4'b0000;
      chk("rr_gap0", int'(req_ready_a), 0);
      tick();
      chk("rr_gap1", int'(req_ready_a), 0);
      tick();
    end
    // Pointer now 1.

    // Flush during HOLD after loading 0x7 from requester 1.
    req_data_a = 16'h0070;
    req_valid_a = 4'b0010;
    qa.push_back('{owner: 1, data: 7});
    #1 chk("fl_load_ready", int'(req_ready_a), 4'b0010);
    tick();
    req_valid_a = 4'b0000;
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    chk("fl_q", int'(q_a), 0);
    chk("fl_q_valid", int'(q_valid_a), 0);
    chk("fl_q_owner", int'(q_owner_a), 0);
    chk("fl_busy", int'(busy_a), 0);
    // Pointer kept at 2: with 0 and 2 valid, requester 2 wins.
    req_data_a = 16'h0501;
    req_valid_a = 4'b0101;
    qa.push_back('{owner: 2, data: 5});
    #1 chk("fl_ptr_kept", int'(req_ready_a), 4'b0100);
    tick();
    req_valid_a = 4'b0000;
    tick();
    tick();

    // Flush in the same cycle as a request in IDLE: no grant, no load.
    req_data_a = 16'h0009;
    req_valid_a = 4'b0001;
    flush_a = 1'b1;
    #1 chk("flreq_ready", int'(req_ready_a), 0);
    tick();
    flush_a = 1'b0;
    chk("flreq_q", int'(q_a), 0);
    chk("flreq_q_valid", int'(q_valid_a), 0);
    qa.push_back('{owner: 0, data: 9});
    #1 chk("flreq_next_ready", int'(req_ready_a), 4'b0001);
    tick();
    req_valid_a = 4'b0000;
    tick();
    tick();

    // Back-to-back on HOLD_CYCLES=0: 0,3,0,3 on consecutive cycles.
    rst_b = 1'b0;
    req_data_b = 16'hD00C;
    req_valid_b = 4'b1001;
    qb.push_back('{owner: 0, data: 4'hC});
    qb.push_back('{owner: 3, data: 4'hD});
    qb.push_back('{owner: 0, data: 4'hC});
    qb.push_back('{owner: 3, data: 4'hD});
    for (int g = 0; g < 4; g++) begin
      #1 chk("b2b_ready", int'(req_ready_b), (g % 2 == 0) ? 4'b0001 : 4'b1000);
      tick();
      if (g == 3) req_valid_b = 4'b0000;
    end
    tick();
    tick();

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
